// File: rtl/a2_bridge_pkg.sv
// Shared definitions for the A2 bridge responder: bus select codes,
// drive FSM states and control register bit positions.
package a2_bridge_pkg;

    // Bridge register select encodings
    localparam logic [1:0] BRIDGE_SEL_CTRL    = 2'd0;
    localparam logic [1:0] BRIDGE_SEL_DATA    = 2'd1;
    localparam logic [1:0] BRIDGE_SEL_ADDR_LO = 2'd2;
    localparam logic [1:0] BRIDGE_SEL_ADDR_HI = 2'd3;

    // control_out_o bit driving the Apple IRQ line (active low)
    localparam int unsigned CTRL_IRQ_N_BIT = 2;

    typedef enum logic {
        DRV_IDLE  = 1'b0,
        DRV_DRIVE = 1'b1
    } drv_state_e;

endpackage

// File: rtl/a2_bridge_drive_fsm.sv
// Apple data bus drive window: opens on a data write, closes on a
// synchronised phi0 falling edge or after HOLD_CYCLES cycles.
module a2_bridge_drive_fsm
    import a2_bridge_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 24
) (
    input  logic clk_logic,
    input  logic rst,
    input  logic arm_i,        // sel1 write edge
    input  logic phi0_sync_i,  // phi0 after the 2-flop synchroniser
    output logic drive_oe_o
);

    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

    drv_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phi0_prev_q;
    logic            phi0_fall;

    assign phi0_fall = phi0_prev_q & ~phi0_sync_i;

    // State, counter and phi0 edge history
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            state_q     <= DRV_IDLE;
            cnt_q       <= '0;
            phi0_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phi0_prev_q <= phi0_sync_i;
        end
    end

    // Next state; a fresh write takes priority over phi0 fall and timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drive_oe_o = (state_q == DRV_DRIVE);
        unique case (state_q)
            DRV_IDLE: begin
                if (arm_i) begin
                    state_d = DRV_DRIVE;
                    cnt_d   = '0;
                end
            end
            DRV_DRIVE: begin
                if (arm_i) begin
                    cnt_d = '0;
                end else if (phi0_fall || (cnt_q == CntLast)) begin
                    state_d = DRV_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = DRV_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/a2_bridge_responder.sv
// Far-end responder of the 8-bit multiplexed A2 bridge bus.
// Optional feature macro: A2_BRIDGE_ADDR_SNAPSHOT_EN -- when defined the
// address/RW snapshot is captured on the start of a sel2 read and held so
// the master reads a coherent addr-lo/addr-hi/status triple.
module a2_bridge_responder
    import a2_bridge_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 24,
    parameter logic [7:0]  CONTROL_RESET = 8'hFF
) (
    input  logic        clk_logic,
    input  logic        rst,
    input  logic [1:0]  bridge_sel_i,
    input  logic        bridge_rd_i,
    input  logic        bridge_wr_i,
    input  logic [7:0]  bridge_d_i,
    output logic [7:0]  bridge_d_o,
    output logic        bridge_d_oe_o,
    input  logic [15:0] apple_addr_i,
    input  logic        apple_rw_n_i,
    input  logic        apple_phi0_i,
    input  logic [7:0]  apple_data_i,
    output logic [7:0]  apple_data_o,
    output logic        apple_data_oe_o,
    input  logic [7:0]  status_i,
    output logic [7:0]  control_out_o
);

    logic        phi0_meta_q, phi0_sync_q;
    logic [7:0]  status_meta_q, status_sync_q;
    logic        wr_prev_q;
    logic [7:0]  control_q;
    logic [7:0]  apple_data_q;
    logic [7:0]  data_snap_q;
    logic [15:0] addr_snap_q;
    logic        rw_snap_q;
    logic [7:0]  read_mux;

    logic wr_edge, ctrl_wr, data_wr, data_rd;
    logic unused_status;

    assign wr_edge = bridge_wr_i & ~wr_prev_q;
    assign ctrl_wr = wr_edge & (bridge_sel_i == BRIDGE_SEL_CTRL);
    assign data_wr = wr_edge & (bridge_sel_i == BRIDGE_SEL_DATA);
    assign data_rd = bridge_rd_i & (bridge_sel_i == BRIDGE_SEL_DATA);

    // status bit 0 is replaced by the RW snapshot on reads
    assign unused_status = status_sync_q[0];

    // Synchronisers for the asynchronous phi0 and status inputs
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            phi0_meta_q   <= 1'b0;
            phi0_sync_q   <= 1'b0;
            status_meta_q <= '0;
            status_sync_q <= '0;
        end else begin
            phi0_meta_q   <= apple_phi0_i;
            phi0_sync_q   <= phi0_meta_q;
            status_meta_q <= status_i;
            status_sync_q <= status_meta_q;
        end
    end

    // Write edge detection, control/data write latches and data snapshot
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            wr_prev_q    <= 1'b0;
            control_q    <= CONTROL_RESET;
            apple_data_q <= '0;
            data_snap_q  <= '0;
        end else begin
            wr_prev_q <= bridge_wr_i;
            if (ctrl_wr) begin
                control_q <= bridge_d_i;
            end
            if (data_wr) begin
                apple_data_q <= bridge_d_i;
            end
            // Frozen while the master reads it so the byte cannot tear
            if (!data_rd) begin
                data_snap_q <= apple_data_i;
            end
        end
    end

`ifdef A2_BRIDGE_ADDR_SNAPSHOT_EN
    logic addr_rd, addr_rd_prev_q, addr_capture;

    assign addr_rd      = bridge_rd_i & (bridge_sel_i == BRIDGE_SEL_ADDR_LO);
    assign addr_capture = addr_rd & ~addr_rd_prev_q;

    // Capture address/RW once at the start of an addr-lo read
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            addr_rd_prev_q <= 1'b0;
            addr_snap_q    <= '0;
            rw_snap_q      <= 1'b0;
        end else begin
            addr_rd_prev_q <= addr_rd;
            if (addr_capture) begin
                addr_snap_q <= apple_addr_i;
                rw_snap_q   <= apple_rw_n_i;
            end
        end
    end
`else
    // Track the live address/RW lines every cycle
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            addr_snap_q <= '0;
            rw_snap_q   <= 1'b0;
        end else begin
            addr_snap_q <= apple_addr_i;
            rw_snap_q   <= apple_rw_n_i;
        end
    end
`endif

    // Read mux from registered sources only
    always_comb begin
        read_mux = '0;
        unique case (bridge_sel_i)
            BRIDGE_SEL_CTRL:    read_mux = {status_sync_q[7:1], rw_snap_q};
            BRIDGE_SEL_DATA:    read_mux = data_snap_q;
            BRIDGE_SEL_ADDR_LO: read_mux = addr_snap_q[7:0];
            BRIDGE_SEL_ADDR_HI: read_mux = addr_snap_q[15:8];
            default:            read_mux = '0;
        endcase
    end

    // A write always wins the shared data lines
    assign bridge_d_oe_o = bridge_rd_i & ~bridge_wr_i;
    assign bridge_d_o    = bridge_d_oe_o ? read_mux : 8'h00;

    assign control_out_o = control_q;
    assign apple_data_o  = apple_data_q;

    a2_bridge_drive_fsm #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_drive_fsm (
        .clk_logic   (clk_logic),
        .rst         (rst),
        .arm_i       (data_wr),
        .phi0_sync_i (phi0_sync_q),
        .drive_oe_o  (apple_data_oe_o)
    );

endmodule

// File: tb/tb_a2_bridge_responder.sv
// Self-checking bench for a2_bridge_responder against a cycle-indexed
// reference model (edge history arrays, window start/stop edge numbers).
module tb_a2_bridge_responder;

    localparam int unsigned HOLD = 24;
    localparam int          HMAX = 8192;

    logic        clk_logic = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        rd, wr;
    logic [7:0]  d_in;
    logic [7:0]  bridge_d_o;
    logic        bridge_d_oe_o;
    logic [15:0] addr;
    logic        rw_n, phi0;
    logic [7:0]  adata_in, apple_data_o, status, control_out_o;
    logic        apple_data_oe_o;

    always #5 clk_logic = ~clk_logic;

    a2_bridge_responder #(
        .HOLD_CYCLES   (HOLD),
        .CONTROL_RESET (8'hFF)
    ) dut (
        .clk_logic       (clk_logic),
        .rst             (rst),
        .bridge_sel_i    (sel),
        .bridge_rd_i     (rd),
        .bridge_wr_i     (wr),
        .bridge_d_i      (d_in),
        .bridge_d_o      (bridge_d_o),
        .bridge_d_oe_o   (bridge_d_oe_o),
        .apple_addr_i    (addr),
        .apple_rw_n_i    (rw_n),
        .apple_phi0_i    (phi0),
        .apple_data_i    (adata_in),
        .apple_data_o    (apple_data_o),
        .apple_data_oe_o (apple_data_oe_o),
        .status_i        (status),
        .control_out_o   (control_out_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: per-edge input history plus edge numbers of events
    bit         ph_h [HMAX];
    logic [7:0] st_h [HMAX];
    logic [7:0] m_ctrl = 8'h00, m_adata = 8'h00, m_snap = 8'h00;
    logic [15:0] m_addr = 16'h0;
    logic       m_rw = 1'b0, m_wr_prev = 1'b0, m_alo_prev = 1'b0;
    int         last_arm = -1000, last_fall = -2000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] st_at(input int i);
        return (i < 0) ? 8'h00 : st_h[i];
    endfunction

    // Apply one clock: check combinational read path, clock, update model, check state
    task automatic cycle();
        logic [7:0] sts, e_d;
        logic       e_oe, e_aoe, w_edge;
        int         k;
        #1;
        sts  = st_at(cyc - 2);
        e_oe = rd && !wr;
        case (sel)
            2'd0:    e_d = {sts[7:1], m_rw};
            2'd1:    e_d = m_snap;
            2'd2:    e_d = m_addr[7:0];
            default: e_d = m_addr[15:8];
        endcase
        if (!e_oe) e_d = 8'h00;
        chk("bridge_d_oe", {15'd0, bridge_d_oe_o}, {15'd0, e_oe});
        chk("bridge_d", {8'd0, bridge_d_o}, {8'd0, e_d});

        @(posedge clk_logic);
        k = cyc;
        ph_h[k] = rst ? 1'b0 : phi0;
        st_h[k] = rst ? 8'h00 : status;
        if (rst) begin
            if (k >= 1) begin ph_h[k-1] = 1'b0; st_h[k-1] = 8'h00; end
            if (k >= 2) begin ph_h[k-2] = 1'b0; end
            m_ctrl = 8'hFF; m_adata = 8'h00; m_snap = 8'h00;
            m_addr = 16'h0; m_rw = 1'b0; m_wr_prev = 1'b0; m_alo_prev = 1'b0;
            last_arm = -1000; last_fall = -2000;
        end else begin
            w_edge = wr && !m_wr_prev;
            if (w_edge && sel == 2'd0) m_ctrl = d_in;
            if (w_edge && sel == 2'd1) begin m_adata = d_in; last_arm = k; end
            // Synchronised phi0 fall reaches the FSM three edges after the pin
            if (k >= 3 && ph_h[k-3] && !ph_h[k-2]) last_fall = k;
            if (!(rd && sel == 2'd1)) m_snap = adata_in;
`ifdef A2_BRIDGE_ADDR_SNAPSHOT_EN
            if (rd && sel == 2'd2 && !m_alo_prev) begin m_addr = addr; m_rw = rw_n; end
            m_alo_prev = rd && (sel == 2'd2);
`else
            m_addr = addr; m_rw = rw_n;
`endif
            m_wr_prev = wr;
        end
        e_aoe = ((k - last_arm) < HOLD) && !(last_fall > last_arm);
        cyc++;

        #1;
        chk("control_out", {8'd0, control_out_o}, {8'd0, m_ctrl});
        chk("apple_data_o", {8'd0, apple_data_o}, {8'd0, m_adata});
        chk("apple_data_oe", {15'd0, apple_data_oe_o}, {15'd0, e_aoe});
        @(negedge clk_logic);
    endtask

    task automatic idle(input int n);
        sel = 2'd0; rd = 1'b0; wr = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; sel = 2'd0; rd = 1'b0; wr = 1'b0; d_in = 8'h00;
        addr = 16'h0; rw_n = 1'b0; phi0 = 1'b1; adata_in = 8'h00; status = 8'h00;
        @(negedge clk_logic);

        // Reset held two cycles
        cycle(); cycle();
        rst = 1'b0;
        idle(3);

        // Address read triple; live address changes after the sel2 read
        addr = 16'hC0A5; rw_n = 1'b1; status = 8'($urandom);
        adata_in = 8'($urandom);
        idle(3);
        sel = 2'd2; rd = 1'b1; cycle();
        addr = 16'h1234; rw_n = 1'b0;
        sel = 2'd3; rd = 1'b1; cycle();
        sel = 2'd0; rd = 1'b1; cycle();
        sel = 2'd1; rd = 1'b1; cycle();
        adata_in = 8'($urandom); cycle();
        idle(2);

        // Control write, wr held two cycles with changed data on the second
        sel = 2'd0; wr = 1'b1; d_in = 8'hFB; cycle();
        d_in = 8'h3C; cycle();
        idle(2);

        // Drive window released by phi0 falling
        sel = 2'd1; wr = 1'b1; d_in = 8'h5A; cycle();
        idle(4);
        phi0 = 1'b0; idle(6);
        phi0 = 1'b1; idle(4);

        // Timeout window with a rewrite at cycle 10
        for (int i = 0; i < 40; i++) begin
            sel = 2'd1; rd = 1'b0;
            wr = (i == 0 || i == 10);
            d_in = 8'($urandom);
            cycle();
        end
        idle(2);

        // Simultaneous rd and wr on sel1
        sel = 2'd1; rd = 1'b1; wr = 1'b1; d_in = 8'hA7; cycle();
        idle(3);

        // Reset while driving
        sel = 2'd1; wr = 1'b1; d_in = 8'h66; cycle();
        idle(3);
        rst = 1'b1; cycle();
        rst = 1'b0; idle(4);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            sel      = 2'($urandom);
            rd       = 1'($urandom);
            wr       = ($urandom_range(0, 3) == 0);
            d_in     = 8'($urandom);
            addr     = 16'($urandom);
            rw_n     = 1'($urandom);
            adata_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) status = 8'($urandom);
            if ($urandom_range(0, 11) == 0) phi0 = ~phi0;
            cycle();
        end
        rst = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
